// File: rtl/ame_num_expand.sv
// Applies a power-of-two code (sign, zero, exponent) to a signed operand by multi-cycle shifting; AME_NUM_EXPAND_SAT_EN adds overflow tracking and saturation.
// Latency floor(code/SHIFT_STEP)+2 cycles (1 when zero is set); comp_init_i is ignored while busy, nothing is queued.
module ame_num_expand #(
  parameter int COMP_DATA_BITS = 64,
  parameter int SHIFT_STEP     = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              comp_init_i,
  output logic                              comp_busy_o,
  output logic                              comp_done_o,
  input  logic                              comp_sign_i,
  input  logic                              comp_zero_i,
  input  logic [$clog2(COMP_DATA_BITS)-1:0] comp_code_i,
  input  logic [COMP_DATA_BITS-1:0]         comp_data_i,
  output logic [COMP_DATA_BITS-1:0]         comp_data_o,
  output logic                              comp_ovf_o
);

  localparam int W  = COMP_DATA_BITS;
  localparam int CW = $clog2(COMP_DATA_BITS);
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, SIGN} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   acc;
  logic [CW-1:0]  remaining;
  logic           sign_q;
  logic           zero_pend;
  logic           accept;
  logic           last_step;
  logic [CW-1:0]  amt;
  logic [W-1:0]   acc_shifted;
  logic [W-1:0]   result_wrap;
  logic [W-1:0]   result_final;

  assign accept      = (state == IDLE) && comp_init_i;
  assign last_step   = remaining < STEP;
  assign amt         = last_step ? remaining : STEP;
  assign result_wrap = sign_q ? (-acc) : acc;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (comp_init_i && !comp_zero_i) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    comp_busy_o = (state != IDLE);
  end

`ifdef AME_NUM_EXPAND_SAT_EN
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS = ~MIN_NEG;

  logic [2*W-1:0] shifted_wide;
  logic [W-1:0]   out_bits;
  logic [W-1:0]   out_mask;
  logic           any_one;
  logic           any_zero;
  logic           op_sign;
  logic           ovf_now;

  // Upper half holds the bits pushed out of the accumulator this cycle.
  assign shifted_wide = {{W{1'b0}}, acc} << amt;
  assign acc_shifted  = shifted_wide[W-1:0];
  assign out_bits     = shifted_wide[2*W-1:W];
  assign out_mask     = (ONE << amt) - ONE;
  assign ovf_now      = (acc[W-1] ? any_zero : any_one) | (sign_q && (acc == MIN_NEG));
  assign result_final = ovf_now ? ((op_sign ^ sign_q) ? MIN_NEG : MAX_POS) : result_wrap;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      any_one    <= 1'b0;
      any_zero   <= 1'b0;
      op_sign    <= 1'b0;
      comp_ovf_o <= 1'b0;
    end else begin
      if (accept) begin
        any_one  <= 1'b0;
        any_zero <= 1'b0;
        op_sign  <= comp_data_i[W-1];
      end else if (state == SHIFT) begin
        any_one  <= any_one  | (|(out_bits & out_mask));
        any_zero <= any_zero | (|(~out_bits & out_mask));
      end
      if (zero_pend)            comp_ovf_o <= 1'b0;
      else if (state == SIGN)   comp_ovf_o <= ovf_now;
    end
  end
`else
  assign acc_shifted  = acc << amt;
  assign result_final = result_wrap;
  assign comp_ovf_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc         <= '0;
      remaining   <= '0;
      sign_q      <= 1'b0;
      zero_pend   <= 1'b0;
      comp_done_o <= 1'b0;
      comp_data_o <= '0;
    end else begin
      // A zero code skips the shifter but still reports one cycle later.
      zero_pend   <= accept && comp_zero_i;
      comp_done_o <= zero_pend || (state == SIGN);
      if (accept) begin
        acc       <= comp_data_i;
        remaining <= comp_code_i;
        sign_q    <= comp_sign_i;
      end else if (state == SHIFT) begin
        acc       <= acc_shifted;
        remaining <= remaining - amt;
      end
      if (zero_pend)          comp_data_o <= '0;
      else if (state == SIGN) comp_data_o <= result_final;
    end
  end

endmodule

// File: doc/ame_num_expand.md
Name: ame_num_expand

Overview:
- Inverse of the AME number approximator: takes a power-of-two code (sign, zero flag, exponent) and applies it to a signed operand.
- Computes result = operand × (±2^code), or 0 when the zero flag is set.
- Implemented as a multi-cycle coarse/fine left shifter with an init/done handshake.
- Sits in the AME datapath after approximation, where multiplication by an approximated coefficient is replaced by shifting.

Parameters:
- COMP_DATA_BITS, 64, operand/result width; power of two, >= 16.
- SHIFT_STEP, 8, bits shifted per coarse cycle; power of two, < COMP_DATA_BITS.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- comp_init_i  in  1  start pulse; accepted only when idle.
- comp_busy_o  out  1  high from the cycle after an accepted init until done.
- comp_done_o  out  1  one-cycle pulse; result valid from this cycle.
- comp_sign_i  in  1  1 = negative approximated value.
- comp_zero_i  in  1  1 = approximated value is zero.
- comp_code_i  in  $clog2(COMP_DATA_BITS)  exponent e.
- comp_data_i  in  COMP_DATA_BITS  signed two's-complement operand.
- comp_data_o  out  COMP_DATA_BITS  signed result; held until the next done.
- comp_ovf_o  out  1  overflow flag; valid with done, held until the next done.

Behaviour:
- Clock and reset: clock clk_i; reset rst_n_i, asynchronous, active-low.
- Reset values: state IDLE; comp_busy_o=0, comp_done_o=0, comp_data_o=0, comp_ovf_o=0; internal registers cleared.
- Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, SHIFT, SIGN.
- IDLE:
  - On comp_init_i, latch data, code, sign and zero.
  - If zero=1: comp_data_o=0, comp_ovf_o=0, done pulse next cycle; stay IDLE.
  - Otherwise: go to SHIFT with remaining = code.
- SHIFT, one action per cycle:
  - If remaining >= SHIFT_STEP: acc <<= SHIFT_STEP, remaining -= SHIFT_STEP, stay in SHIFT.
  - Otherwise: acc <<= remaining (0..SHIFT_STEP-1), go to SIGN.
- SIGN:
  - Result = sign ? -acc : acc, registered into comp_data_o.
  - comp_done_o=1 for one cycle; return to IDLE.
- Latency, counted from the init sampling edge to the done cycle:
  - L = floor(e/SHIFT_STEP) + 2.
  - Zero flag: L = 1.
  - Worst case (default parameters, e=63): L = 9.
- comp_busy_o is high during SHIFT and SIGN, low in IDLE.
- comp_init_i while busy is ignored; no queueing; latched inputs are unchanged.
- Init in the same cycle as done (FSM back in IDLE next cycle): accepted on the following edge; no gap cycle is required.
- Bits shifted out are tracked for overflow detection: true product sign = operand sign XOR comp_sign_i.
- Overflow is set when either holds:
  - any shifted-out bit differs from the final acc sign bit; or
  - negating the minimum negative value.
- Width rules: all arithmetic is COMP_DATA_BITS wide, modulo 2^COMP_DATA_BITS.
- e = 0 with operand 0: result 0, no overflow.

Optional Feature:
- Macro: AME_NUM_EXPAND_SAT_EN.
- Defined:
  - On overflow, comp_data_o saturates to max positive (0x7FF..F) when the true product sign is 0, or min negative (0x800..0) when it is 1.
  - comp_ovf_o=1 with that done pulse.
- Undefined:
  - comp_data_o is the wrapped result.
  - comp_ovf_o is tied to 0.
  - No overflow-tracking logic is synthesized.

Test Plan:
- data=3, code=5, sign=0 -> comp_data_o=96; done 2 cycles after init; busy high for 2 cycles.
- data=3, code=20, sign=1 -> comp_data_o=-3145728 (0xFFFF_FFFF_FFD0_0000); done 4 cycles after init.
- zero=1, data=0x1234, code=40 -> comp_data_o=0, ovf=0; done 1 cycle after init; busy never high.
- data=1, code=63, sign=0:
  - without macro -> 0x8000_0000_0000_0000, ovf=0;
  - with macro -> 0x7FFF_FFFF_FFFF_FFFF, ovf=1;
  - done after 9 cycles.
- init with data=5, code=16; second init with data=7, code=0 two cycles later -> second init ignored; result 327680, done at L=4; fresh init accepted next cycle.
- rst_n_i asserted during SHIFT of a code=48 operation -> all outputs 0 immediately; no done pulse; next init with data=2, code=1 -> 4.
